// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - shared FSM state type, counter width and index-width helper for mem_responder
package mem_responder_pkg;

  // Width of the wait-state counter; covers WAIT_CYCLES 0..15
  localparam int WAIT_CNT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Ceiling log2, used to size the word index from DEPTH
  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_resp_array.sv
// rtl/mem_resp_array.sv - DEPTH x DATA_WIDTH register array, async clear, sync write, comb read
module mem_resp_array
  import mem_responder_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int IDX_W      = log2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [IDX_W-1:0]      index,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [15:0]           test_value
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Word storage: cleared by reset, written on the commit edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[index] <= wdata;
    end
  end

  assign rdata      = mem[index];
  assign test_value = mem[0][15:0];

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - wait-state load/store memory responder; optional address checking under MEM_RESP_ERR_CHECK_EN
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [15:0]           test_value
);

  localparam int IDX_W = log2(DEPTH);
  localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LOAD = WAIT_CNT_WIDTH'(WAIT_CYCLES);
  localparam logic [WAIT_CNT_WIDTH-1:0] CNT_ONE   = WAIT_CNT_WIDTH'(1);

  state_t state, state_nxt;
  logic [WAIT_CNT_WIDTH-1:0] cnt;

  logic                  cap_we;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [DATA_WIDTH-1:0] cap_wdata;

  logic                  accept;
  logic                  do_access;
  logic                  acc_we;
  logic                  acc_err;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [IDX_W-1:0]      acc_index;

  assign accept    = (state == ST_IDLE) && req_valid;
  // With zero wait states the access happens on the accepting edge itself,
  // so the live request fields feed the array instead of the captured copy.
  assign do_access = (accept && (WAIT_CYCLES == 0)) || ((state == ST_WAIT) && (cnt == CNT_ONE));
  assign acc_we    = (state == ST_IDLE) ? req_we    : cap_we;
  assign acc_addr  = (state == ST_IDLE) ? req_addr  : cap_addr;
  assign acc_wdata = (state == ST_IDLE) ? req_wdata : cap_wdata;
  assign acc_index = acc_addr[IDX_W+1:2];

`ifdef MEM_RESP_ERR_CHECK_EN
  assign acc_err = (acc_addr[1:0] != '0) || (acc_addr[ADDR_WIDTH-1:IDX_W+2] != '0);
`else
  // Byte offset and high address bits are deliberately ignored; index wraps
  logic unused_addr_bits;
  assign unused_addr_bits = ^{acc_addr[ADDR_WIDTH-1:IDX_W+2], acc_addr[1:0]};
  assign acc_err = 1'b0;
`endif

  mem_resp_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .IDX_W     (IDX_W)
  ) u_array (
    .clk       (CLK),
    .rst       (RST),
    .we        (do_access && acc_we && !acc_err),
    .index     (acc_index),
    .wdata     (acc_wdata),
    .rdata     (mem_rdata),
    .test_value(test_value)
  );

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (cnt == CNT_ONE) state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs are pure state decodes
  always_comb begin
    req_ready = (state == ST_IDLE);
    rsp_valid = (state == ST_RESP);
  end

  // Wait-state counter: loaded on accept, counts down while waiting
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= WAIT_LOAD;
    end else if ((state == ST_WAIT) && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Request capture for the deferred access
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else if (accept) begin
      cap_we    <= req_we;
      cap_addr  <= req_addr;
      cap_wdata <= req_wdata;
    end
  end

  // Response registers: written only on the access edge, held through RESP
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (do_access) begin
      rsp_rdata <= (acc_we || acc_err) ? '0 : mem_rdata;
      rsp_err   <= acc_err;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder with WAIT_CYCLES 2 and 0 instances
module tb_mem_responder;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  logic        v  [2];
  logic        w  [2];
  logic        rr [2];
  logic [31:0] ad [2];
  logic [31:0] wd [2];
  logic        rdy[2];
  logic        rv [2];
  logic        re [2];
  logic [31:0] rd [2];
  logic [15:0] tv [2];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 CLK = ~CLK;

  mem_responder #(.WAIT_CYCLES(2)) u_dut_n2 (
    .CLK(CLK), .RST(RST),
    .req_valid(v[0]), .req_ready(rdy[0]), .req_we(w[0]), .req_addr(ad[0]), .req_wdata(wd[0]),
    .rsp_valid(rv[0]), .rsp_ready(rr[0]), .rsp_rdata(rd[0]), .rsp_err(re[0]), .test_value(tv[0])
  );

  mem_responder #(.WAIT_CYCLES(0)) u_dut_n0 (
    .CLK(CLK), .RST(RST),
    .req_valid(v[1]), .req_ready(rdy[1]), .req_we(w[1]), .req_addr(ad[1]), .req_wdata(wd[1]),
    .rsp_valid(rv[1]), .rsp_ready(rr[1]), .rsp_rdata(rd[1]), .rsp_err(re[1]), .test_value(tv[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Transaction-level reference: one outstanding request, response due a fixed
  // number of edges after acceptance, held until the requester takes it.
  logic [31:0] m_mem [2][64];
  bit          m_busy[2];
  bit          m_resp[2];
  int          m_left[2];
  logic        m_cw  [2];
  logic [31:0] m_ca  [2];
  logic [31:0] m_cd  [2];
  logic [31:0] m_rdata[2];
  logic        m_err [2];
  int          m_acc_t[2];
  int          m_prev_acc_t[2];
  int          edge_n = 0;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 64; i++) m_mem[k][i] = 32'h0;
      m_busy[k] = 0; m_resp[k] = 0; m_left[k] = 0;
      m_rdata[k] = 32'h0; m_err[k] = 1'b0;
    end
  endtask

  task automatic model_access(input int k);
    int idx;
    bit e;
    idx = int'((m_ca[k] >> 2) % 64);
`ifdef MEM_RESP_ERR_CHECK_EN
    e = (m_ca[k] % 4 != 0) || (m_ca[k] / 4 >= 64);
`else
    e = 0;
`endif
    m_err[k] = e;
    if (e) m_rdata[k] = 32'h0;
    else if (m_cw[k]) begin
      m_mem[k][idx] = m_cd[k];
      m_rdata[k] = 32'h0;
    end else m_rdata[k] = m_mem[k][idx];
  endtask

  task automatic model_edge(input int k, input int n);
    if (m_resp[k]) begin
      if (rr[k]) begin m_resp[k] = 0; m_busy[k] = 0; end
    end else if (m_busy[k]) begin
      m_left[k]--;
      if (m_left[k] == 0) begin model_access(k); m_resp[k] = 1; end
    end else if (v[k]) begin
      m_busy[k] = 1;
      m_cw[k] = w[k]; m_ca[k] = ad[k]; m_cd[k] = wd[k];
      m_prev_acc_t[k] = m_acc_t[k];
      m_acc_t[k] = edge_n;
      m_left[k] = n;
      if (n == 0) begin model_access(k); m_resp[k] = 1; end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge CLK);
      edge_n++;
      if (RST) model_reset();
      else begin
        model_edge(0, 2);
        model_edge(1, 0);
      end
    end
  end

  // Per-cycle comparison against the reference, just after each edge
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("req_ready[%0d]", k), {31'h0, rdy[k]}, {31'h0, !m_busy[k]});
        chk($sformatf("rsp_valid[%0d]", k), {31'h0, rv[k]}, {31'h0, m_resp[k]});
        chk($sformatf("test_value[%0d]", k), {16'h0, tv[k]}, {16'h0, m_mem[k][0][15:0]});
        if (m_resp[k] || RST) begin
          chk($sformatf("rsp_rdata[%0d]", k), rd[k], m_rdata[k]);
          chk($sformatf("rsp_err[%0d]", k), {31'h0, re[k]}, {31'h0, m_err[k]});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one request; returns at the first negedge with rsp_valid high.
  // lat counts edges from the accepting edge to the rise of rsp_valid.
  task automatic issue(input int k, input bit we_i, input logic [31:0] a, input logic [31:0] d,
                       input bit rr_i, output int lat);
    @(negedge CLK);
    v[k] = 1'b1; w[k] = we_i; ad[k] = a; wd[k] = d; rr[k] = rr_i;
    @(posedge CLK);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      v[k] = 1'b0;
      if (rv[k]) begin lat = i; break; end
    end
    if (lat < 0) chk($sformatf("rsp_timeout[%0d]", k), {31'h0, rv[k]}, 32'h1);
  endtask

  logic [31:0] b_addrs[3] = '{32'h4, 32'h8, 32'hC};
  logic [31:0] b_vals [3] = '{32'hA1A1_0001, 32'hB2B2_0002, 32'hC3C3_0003};

  initial begin
    int lat;
    for (int k = 0; k < 2; k++) begin
      v[k] = 1'b0; w[k] = 1'b0; rr[k] = 1'b1; ad[k] = 32'h0; wd[k] = 32'h0;
    end

    // Reset state
    repeat (2) @(negedge CLK);
    chk("reset req_ready", {31'h0, rdy[0]}, 32'h1);
    chk("reset rsp_valid", {31'h0, rv[0]}, 32'h0);
    chk("reset rsp_rdata", rd[0], 32'h0);
    chk("reset rsp_err", {31'h0, re[0]}, 32'h0);
    chk("reset test_value", {16'h0, tv[0]}, 32'h0);
    RST = 1'b0;

    // Reset asserted while a store to word 0 is waiting
    @(negedge CLK);
    v[0] = 1'b1; w[0] = 1'b1; ad[0] = 32'h0; wd[0] = 32'h1111_2222; rr[0] = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    v[0] = 1'b0;
    RST = 1'b1;
    #1;
    chk("midwait reset req_ready", {31'h0, rdy[0]}, 32'h1);
    chk("midwait reset rsp_valid", {31'h0, rv[0]}, 32'h0);
    chk("midwait reset test_value", {16'h0, tv[0]}, 32'h0);
    repeat (3) @(negedge CLK);
    chk("after reset test_value", {16'h0, tv[0]}, 32'h0);
    RST = 1'b0;
    issue(0, 1'b0, 32'h0, 32'h0, 1'b1, lat);
    chk("word0 after reset", rd[0], 32'h0);

    // Store with two wait states, response taken immediately
    issue(0, 1'b1, 32'h0, 32'h1234_5678, 1'b1, lat);
    chk("store latency n2", lat, 32'd2);
    chk("store test_value", {16'h0, tv[0]}, 32'h0000_5678);
    chk("store rsp_err", {31'h0, re[0]}, 32'h0);
    chk("store rsp_rdata", rd[0], 32'h0);
    @(negedge CLK);
    chk("store rsp_valid one cycle", {31'h0, rv[0]}, 32'h0);

    // Load with the response held off for five cycles
    issue(0, 1'b1, 32'h3C, 32'hDEAD_BEEF, 1'b1, lat);
    issue(0, 1'b0, 32'h3C, 32'h0, 1'b0, lat);
    chk("load latency n2", lat, 32'd2);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("held rdata %0d", i), rd[0], 32'hDEAD_BEEF);
      chk($sformatf("held valid %0d", i), {31'h0, rv[0]}, 32'h1);
      chk($sformatf("held ready %0d", i), {31'h0, rdy[0]}, 32'h0);
      v[0] = (i % 2 == 0); w[0] = 1'b1; ad[0] = 32'h0; wd[0] = 32'h0BAD_0BAD;
      @(negedge CLK);
    end
    v[0] = 1'b0;
    rr[0] = 1'b1;
    @(negedge CLK);
    chk("held released", {31'h0, rv[0]}, 32'h0);
    issue(0, 1'b0, 32'h0, 32'h0, 1'b1, lat);
    chk("word0 untouched by ignored pulses", rd[0], 32'h1234_5678);

`ifdef MEM_RESP_ERR_CHECK_EN
    issue(0, 1'b1, 32'h2, 32'hFFFF_FFFF, 1'b1, lat);
    chk("misaligned rsp_err", {31'h0, re[0]}, 32'h1);
    chk("misaligned rsp_rdata", rd[0], 32'h0);
    issue(0, 1'b1, 32'h100, 32'hFFFF_FFFF, 1'b1, lat);
    chk("range rsp_err", {31'h0, re[0]}, 32'h1);
    chk("range rsp_rdata", rd[0], 32'h0);
    issue(0, 1'b0, 32'h0, 32'h0, 1'b1, lat);
    chk("word0 unchanged by errors", rd[0], 32'h1234_5678);
    issue(0, 1'b0, 32'h3C, 32'h0, 1'b1, lat);
    chk("word15 unchanged by errors", rd[0], 32'hDEAD_BEEF);
`else
    issue(0, 1'b1, 32'h102, 32'h0000_A5A5, 1'b1, lat);
    chk("wrap rsp_err", {31'h0, re[0]}, 32'h0);
    chk("wrap test_value", {16'h0, tv[0]}, 32'h0000_A5A5);
    issue(0, 1'b0, 32'h0, 32'h0, 1'b1, lat);
    chk("wrap word0 readback", rd[0], 32'h0000_A5A5);
`endif

    // Zero wait states: preload, then back-to-back loads
    for (int i = 0; i < 3; i++) begin
      issue(1, 1'b1, b_addrs[i], b_vals[i], 1'b1, lat);
      chk($sformatf("n0 store latency %0d", i), lat, 32'd0);
    end
    @(negedge CLK);
    v[1] = 1'b1; w[1] = 1'b0; rr[1] = 1'b1; ad[1] = b_addrs[0];
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      chk($sformatf("n0 load valid %0d", i), {31'h0, rv[1]}, 32'h1);
      chk($sformatf("n0 load rdata %0d", i), rd[1], b_vals[i]);
      if (i > 0) chk($sformatf("n0 period %0d", i), m_acc_t[1] - m_prev_acc_t[1], 32'd2);
      if (i < 2) ad[1] = b_addrs[i+1];
      else v[1] = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      chk($sformatf("n0 ready again %0d", i), {31'h0, rdy[1]}, 32'h1);
    end

    @(negedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Wait-state data memory responder: the target end of the processor's load/store interface. It accepts one word request at a time through a valid/ready handshake, inserts a configurable number of wait states, then commits the write or returns the read data through a held response handshake. It sits beside the MIPS top level as the multi-cycle replacement for the zero-latency data memory. Like that memory, it drives `test_value` from word 0.

## Interface
- `DATA_WIDTH`, 32, data word width in bits.
- `ADDR_WIDTH`, 32, byte address width in bits.
- `DEPTH`, 64, number of words; must be a power of two.
- `WAIT_CYCLES`, 2, wait states inserted between accept and access; range 0–15.

Ports:
- `CLK`  in  1  single clock; all state changes on the rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  ADDR_WIDTH  byte address.
- `req_wdata`  in  DATA_WIDTH  store data.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  requester consumes the response.
- `rsp_rdata`  out  DATA_WIDTH  load data; 0 for stores and errors.
- `rsp_err`  out  1  request rejected (see Configuration).
- `test_value`  out  16  `mem[0][15:0]`.

## Operation
- The FSM has three states: IDLE, WAIT and RESP.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid && req_ready`, the block captures `req_we`, `req_addr` and `req_wdata`, and loads the counter with `WAIT_CYCLES`.
  - If `WAIT_CYCLES == 0`, it performs the access on that same edge and goes to RESP. Otherwise it goes to WAIT.
- **WAIT**
  - The counter decrements on each edge.
  - On the edge where the counter goes from 1 to 0, the block performs the access and goes to RESP.
- **Access**
  - Word index = `addr[log2(DEPTH)+1:2]`.
  - Store: writes `mem[index]` and sets `rsp_rdata` = 0.
  - Load: latches `mem[index]` into `rsp_rdata`.
  - On error: no write, `rsp_rdata` = 0, `rsp_err` = 1.
- **RESP**
  - `rsp_valid` = 1.
  - `rsp_rdata` and `rsp_err` are held stable until `rsp_valid && rsp_ready`, then the FSM returns to IDLE.
- Requests are not pipelined: `req_ready` = 0 in WAIT and RESP, and `req_valid` is ignored there.
- `test_value` updates on the edge that commits a store to word 0.

## Timing
- Reset values:
  - `req_ready` = 1.
  - `rsp_valid` = 0.
  - `rsp_rdata` = 0.
  - `rsp_err` = 0.
  - `test_value` = 0.
  - All memory words = 0.
  - State = IDLE, counter = 0.
- Latency: `rsp_valid` rises N edges after the accepting edge, with N = `WAIT_CYCLES`.
  - N = 0: `rsp_valid` is high in the cycle immediately after acceptance.
- The minimum request-to-request period is N + 2 cycles when `rsp_ready` is held high.
- If `rsp_ready` is already high when `rsp_valid` rises, the response completes on the next edge.
- Reset asserted mid-operation aborts the request immediately. Any store not yet committed is lost, and all outputs return to their reset values.
- Outputs are registered or state-decoded only. There is no combinational path from request inputs to `req_ready` or to any `rsp_*` output.

## Configuration
- Macro: `MEM_RESP_ERR_CHECK_EN`.
- When defined, `rsp_err` = 1 if either condition holds:
  - `addr[1:0] != 0` (misaligned address);
  - `addr >> 2 >= DEPTH` (address out of range).
- When not defined:
  - `rsp_err` is tied to 0.
  - `addr[1:0]` are ignored.
  - The word index wraps modulo `DEPTH`.

## Structure
- A shared package holds:
  - the FSM state enum (IDLE, WAIT, RESP);
  - the `WAIT_CNT_WIDTH` constant (4);
  - the macro-independent index-width function `log2(DEPTH)`.
- One sub-module, `mem_resp_array`: the DEPTH×DATA_WIDTH register array.
  - Asynchronously cleared, with a synchronous write port and a combinational read port.
  - Exposes word 0's low 16 bits as `test_value`.
- The FSM, counter and response registers live in `mem_responder`.

## Test plan
- **Reset:** assert `RST` mid-WAIT of a store to 0x0 → `test_value` stays 0x0000, `req_ready` = 1, `rsp_valid` = 0 immediately, and `mem[0]` reads back 0.
- **Store with wait states:** N = 2, store 0x12345678 to 0x0 with `rsp_ready` = 1 → `rsp_valid` is high for exactly 1 cycle, 2 edges after accept; `test_value` = 0x5678 from the same edge; `rsp_err` = 0.
- **Load with held response:** N = 2, store 0xDEADBEEF to 0x3C, then load 0x3C with `rsp_ready` = 0 for 5 cycles → `rsp_rdata` = 0xDEADBEEF stable for all 5 cycles, and `req_valid` pulses during that time are not accepted.
- **Zero wait states:** N = 0, back-to-back loads with `rsp_ready` = 1 → each response arrives 1 cycle after accept, giving a 2-cycle request period.
- **Error check on:** with `MEM_RESP_ERR_CHECK_EN` defined, store to 0x2 and to 0x100 (DEPTH = 64) → `rsp_err` = 1, `rsp_rdata` = 0, and all memory words are unchanged.
- **Error check off:** with the macro undefined, store 0xA5A5 to 0x102 → the write lands in word 0, `test_value` = 0xA5A5, `rsp_err` = 0.
